fifo_wr_arbiter: RTL

//  Round-robin write-port arbiter for the async FIFO. Shares the FIFO write side (data_in/wr_en,

---
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-based arbiter that shares the async FIFO write port among NUM_REQ
// producers in the write clock domain. The owner keeps the port for up to BURST_LEN beats.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned Data_Width = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned STALL_W    = 16,
  localparam int unsigned CntW      = $clog2(BURST_LEN + 1)
) (
  input  logic                          i_wr_clk,
  input  logic                          i_wr_rstn,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*Data_Width-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_gnt,
  input  logic                          i_full,
  output logic                          o_wr_en,
  output logic [Data_Width-1:0]         o_data_in,
  output logic                          o_busy,
  output logic [CntW-1:0]               o_beat_cnt,
  output logic [STALL_W-1:0]            o_stall_cnt
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [PtrW-1:0]    r_rr_ptr;
  logic [CntW-1:0]    r_beat_cnt;
  logic [STALL_W-1:0] r_stall_cnt;

  logic [PtrW-1:0]    w_owner_idx;
  logic               w_owner_req;
  logic               w_busy;
  logic               w_beat;
  logic               w_stall;
  logic               w_last_beat;
  logic               w_end;
  logic [PtrW-1:0]    w_next_ptr;
  logic [PtrW-1:0]    w_arb_ptr;
  logic [NUM_REQ-1:0] w_arb_mask;
  logic               w_win_vld;
  logic [NUM_REQ-1:0] w_win_oh;

  assign w_busy      = (r_state == StBurst);
  assign w_owner_req = |(i_req & r_gnt);
  assign w_beat      = w_busy && w_owner_req && !i_full;
  assign w_stall     = w_busy && w_owner_req && i_full;
  assign w_last_beat = w_beat && (r_beat_cnt == CntW'(BURST_LEN - 1));
  // A burst ends on its final beat or as soon as the owner stops requesting; full never ends it.
  assign w_end       = w_busy && (w_last_beat || !w_owner_req);
  assign w_next_ptr  = (w_owner_idx == PtrW'(NUM_REQ - 1)) ? '0 : w_owner_idx + 1'b1;

  // Encode the one-hot grant into the owner index.
  always_comb begin
    w_owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) w_owner_idx = PtrW'(i);
    end
  end

  // Round-robin pick: first masked request at or after the pointer, wrapping.
  // At burst end the old owner is masked out and the search starts just past it.
  always_comb begin
    int unsigned v_idx;
    w_arb_ptr  = w_busy ? w_next_ptr : r_rr_ptr;
    w_arb_mask = w_busy ? (i_req & ~r_gnt) : i_req;
    w_win_vld  = 1'b0;
    w_win_oh   = '0;
    v_idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = int'(w_arb_ptr) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_win_vld && w_arb_mask[v_idx]) begin
        w_win_vld       = 1'b1;
        w_win_oh[v_idx] = 1'b1;
      end
    end
  end

  // Write-side outputs are gated by the registered grant, so reset drops them immediately.
  always_comb begin
    o_wr_en   = w_beat;
    o_ack     = w_beat ? r_gnt : '0;
    o_data_in = '0;
    if (w_beat) o_data_in = i_req_data[w_owner_idx*Data_Width +: Data_Width];
  end

  // Arbiter FSM: grant, round-robin pointer, beat and saturating stall counters.
  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      r_state     <= StIdle;
      r_gnt       <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      case (r_state)
        StIdle: begin
          if (w_win_vld) begin
            r_state    <= StBurst;
            r_gnt      <= w_win_oh;
            r_beat_cnt <= '0;
          end
        end
        StBurst: begin
          if (w_end) begin
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= '0;
            if (w_win_vld) begin
              r_gnt <= w_win_oh;
            end else begin
              r_state <= StIdle;
              r_gnt   <= '0;
            end
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_busy      = w_busy;
  assign o_beat_cnt  = r_beat_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule
